// File: rtl/sdm_test_source.sv
// sdm_test_source
// ---------------------------------------------------------------------------
// Second-order error-feedback delta-sigma modulator. It turns a 12-bit
// unsigned DC code into a 1-bit stream for feeding digital_filter.data_in.
// The noise transfer function is (1 - z^-1)^2. A new code is taken only on
// frame boundaries (FRAME_LEN enabled samples), so every bit of a frame is
// modulated from a single code.
//
// Parameters:
//   FRAME_LEN    enabled samples per frame; power of two, 2..4096
//
// Ports:
//   clk          system clock (shared with digital_filter)
//   rst          asynchronous active-high reset
//   en           sample enable; when low all state holds
//   code_in      unsigned DC code, sampled only when cnt == 0
//   bit_out      registered modulator bit
//   frame_start  registered one-cycle flag on the first bit of a frame
//   code_q       code currently being modulated
//
// Optional feature:
//   SDM_DITHER_EN  when defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1,
//                  seed 16'hACE1) adds its bit 0 to the loop sum. This breaks up
//                  idle tones. When undefined, the output is fully deterministic
//                  from reset.
// ---------------------------------------------------------------------------
module sdm_test_source #(
    parameter int FRAME_LEN = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] code_in,
    output logic        bit_out,
    output logic        frame_start,
    output logic [11:0] code_q
);

    localparam int CW = $clog2(FRAME_LEN);

    logic [CW-1:0]       cnt;
    logic signed [12:0]  u;       // code_q - 2048
    logic signed [12:0]  e1, e2;  // quantisation error history

    logic signed [14:0]  u_x, e1_x, e2_x;
    logic signed [14:0]  w;
    logic signed [12:0]  ws;
    logic signed [12:0]  q;
    logic signed [12:0]  e;
    logic                y;

`ifdef SDM_DITHER_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
`endif

    // Loop sum, saturation and 1-bit quantiser
    always_comb begin
        u_x  = {{2{u[12]}},  u};
        e1_x = {{2{e1[12]}}, e1};
        e2_x = {{2{e2[12]}}, e2};
`ifdef SDM_DITHER_EN
        w = u_x - (e1_x <<< 1) + e2_x + $signed({14'd0, lfsr[0]});
`else
        w = u_x - (e1_x <<< 1) + e2_x;
`endif
        // The saturated value fits 13 bits. Its sign bit is then the quantiser decision.
        if (w > 15'sd4095)
            ws = 13'sd4095;
        else if (w < -15'sd4096)
            ws = -13'sd4096;
        else
            ws = w[12:0];
        y = ~ws[12];
        q = y ? 13'sd2048 : -13'sd2048;
        // ws in [-4096,4095] and q = +/-2048, so e in [-2048,2047] never wraps.
        e = ws - q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            u           <= -13'sd2048;
            e1          <= '0;
            e2          <= '0;
            bit_out     <= 1'b0;
            frame_start <= 1'b0;
            code_q      <= '0;
        end else if (en) begin
            e2          <= e1;
            e1          <= e;
            bit_out     <= y;
            cnt         <= cnt + CW'(1);
            // The bit computed on this cycle still uses the old u. The new code
            // therefore shows up first on the cnt==1 bit, which is the one flagged by frame_start.
            if (cnt == '0) begin
                code_q <= code_in;
                u      <= $signed({1'b0, code_in}) - 13'sd2048;
            end
            frame_start <= (cnt == CW'(1));
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef SDM_DITHER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (en)
            lfsr <= {lfsr_fb, lfsr[15:1]};
    end
`endif

endmodule

// File: tb/tb_sdm_test_source.sv
module tb_sdm_test_source;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [11:0] code_in = 12'd0;
    logic        bit_out;
    logic        frame_start;
    logic [11:0] code_q;

    int checks   = 0;
    int failures = 0;

    sdm_test_source #(.FRAME_LEN(512)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .code_in     (code_in),
        .bit_out     (bit_out),
        .frame_start (frame_start),
        .code_q      (code_q)
    );

    always #5 clk = ~clk;

    task automatic step_en();
        en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step_dis();
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [11:0] c);
        en      = 1'b0;
        code_in = c;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Mid-scale (code 2048) stream after reset. Edge k is the k-th enabled edge.
    // The first bit still uses u=-2048 and gives 0. Then the stream is 1,1,0,1,0,...
    function automatic logic mid_bit(input int k);
        if (k == 1) return 1'b0;
        if (k == 2) return 1'b1;
        return k[0];
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        #2;
        checks++; if (bit_out !== 1'b0)     begin failures++; $display("FAIL rst_bit got=%b exp=0", bit_out); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
        checks++; if (code_q !== 12'd0)     begin failures++; $display("FAIL rst_code got=%0d exp=0", code_q); end
        apply_reset(12'd2048);
        for (int k = 1; k <= 301; k++) step_en();
        checks++; if (code_q !== 12'd2048) begin failures++; $display("FAIL pre_rst_code got=%0d exp=2048", code_q); end
        checks++; if (bit_out !== 1'b1)    begin failures++; $display("FAIL pre_rst_bit got=%b exp=1", bit_out); end
        // Asynchronous reset partway through the frame. The effect must appear before the next edge.
        #2 rst = 1'b1;
        #1;
        checks++; if (bit_out !== 1'b0)     begin failures++; $display("FAIL async_rst_bit got=%b exp=0", bit_out); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL async_rst_fs got=%b exp=0", frame_start); end
        checks++; if (code_q !== 12'd0)     begin failures++; $display("FAIL async_rst_code got=%0d exp=0", code_q); end
        @(negedge clk) rst = 1'b0;
        step_en();
        checks++; if (code_q !== 12'd2048)  begin failures++; $display("FAIL restart_load got=%0d exp=2048", code_q); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL restart_fs1 got=%b exp=0", frame_start); end
        checks++; if (bit_out !== 1'b0)     begin failures++; $display("FAIL restart_bit1 got=%b exp=0", bit_out); end
        step_en();
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL restart_fs2 got=%b exp=1", frame_start); end
        checks++; if (bit_out !== 1'b1)     begin failures++; $display("FAIL restart_bit2 got=%b exp=1", bit_out); end
    endtask

    task automatic test_midscale();
        int ones1, ones2;
        ones1 = 0; ones2 = 0;
        apply_reset(12'd2048);
        for (int k = 1; k <= 1025; k++) begin
            step_en();
            checks++; if (bit_out !== mid_bit(k)) begin failures++; $display("FAIL mid_bit k=%0d got=%b exp=%b", k, bit_out, mid_bit(k)); end
            checks++; if (frame_start !== ((k % 512) == 2)) begin failures++; $display("FAIL mid_fs k=%0d got=%b exp=%b", k, frame_start, (k % 512) == 2); end
            if (k >= 2 && k <= 513)   ones1 += int'(bit_out);
            if (k >= 514 && k <= 1025) ones2 += int'(bit_out);
        end
        checks++; if (ones1 < 255 || ones1 > 257) begin failures++; $display("FAIL mid_ones_f1 got=%0d exp=256+-1", ones1); end
        checks++; if (ones2 < 255 || ones2 > 257) begin failures++; $display("FAIL mid_ones_f2 got=%0d exp=256+-1", ones2); end
    endtask

    // Codes at quarter and three-quarter scale. From a zeroed loop, their bit patterns
    // are 0,0,1,0 and 1,1,0,1 (period 4).
    task automatic test_density();
        logic [11:0] codes [2];
        logic [3:0]  pats  [2];
        logic [3:0]  pat;
        int ones, target;
        codes[0] = 12'd1024; pats[0] = 4'b0100;
        codes[1] = 12'd3072; pats[1] = 4'b1011;
        for (int c = 0; c < 2; c++) begin
            apply_reset(codes[c]);
            pat    = pats[c];
            target = int'(codes[c]) / 8;
            step_en();
            for (int f = 0; f < 3; f++) begin
                ones = 0;
                for (int i = 0; i < 512; i++) begin
                    step_en();
                    if (i == 0) begin
                        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL dens_fs code=%0d f=%0d got=%b exp=1", codes[c], f, frame_start); end
                    end
                    if (f == 0 && i < 8) begin
                        checks++; if (bit_out !== pat[i % 4]) begin failures++; $display("FAIL dens_pat code=%0d i=%0d got=%b exp=%b", codes[c], i, bit_out, pat[i % 4]); end
                    end
                    ones += int'(bit_out);
                end
                if (f >= 1) begin
                    checks++; if (ones < target - 2 || ones > target + 2) begin failures++; $display("FAIL dens_ones code=%0d f=%0d got=%0d exp=%0d+-2", codes[c], f, ones, target); end
                end
            end
        end
    endtask

    task automatic test_code_change();
        int ones_a, ones_b;
        ones_a = 0; ones_b = 0;
        apply_reset(12'd1024);
        step_en();
        checks++; if (code_q !== 12'd1024) begin failures++; $display("FAIL chg_load got=%0d exp=1024", code_q); end
        for (int k = 2; k <= 1025; k++) begin
            step_en();
            if (k == 100) code_in = 12'd3072;
            if (k <= 513) ones_a += int'(bit_out); else ones_b += int'(bit_out);
            if (k == 512) begin
                checks++; if (code_q !== 12'd1024) begin failures++; $display("FAIL chg_hold got=%0d exp=1024", code_q); end
            end
            if (k == 513) begin
                checks++; if (code_q !== 12'd3072) begin failures++; $display("FAIL chg_update got=%0d exp=3072", code_q); end
            end
        end
        checks++; if (ones_a < 126 || ones_a > 130) begin failures++; $display("FAIL chg_ones_a got=%0d exp=128+-2", ones_a); end
        checks++; if (ones_b < 382 || ones_b > 386) begin failures++; $display("FAIL chg_ones_b got=%0d exp=384+-2", ones_b); end
    endtask

    task automatic test_enable();
        int ones;
        ones = 0;
        apply_reset(12'd2048);
        for (int k = 1; k <= 2; k++) step_en();
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL en_fs_pre got=%b exp=1", frame_start); end
        ones += int'(bit_out);
        for (int d = 0; d < 5; d++) begin
            step_dis();
            checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL en_fs_drop d=%0d got=%b exp=0", d, frame_start); end
            checks++; if (bit_out !== 1'b1)     begin failures++; $display("FAIL en_hold1 d=%0d got=%b exp=1", d, bit_out); end
        end
        for (int k = 3; k <= 514; k++) begin
            step_en();
            checks++; if (bit_out !== mid_bit(k)) begin failures++; $display("FAIL en_bit k=%0d got=%b exp=%b", k, bit_out, mid_bit(k)); end
            checks++; if (frame_start !== (k == 514)) begin failures++; $display("FAIL en_fs k=%0d got=%b exp=%b", k, frame_start, k == 514); end
            if (k <= 513) ones += int'(bit_out);
            if (k == 200) begin
                for (int d = 0; d < 37; d++) begin
                    step_dis();
                    checks++; if (bit_out !== 1'b0)     begin failures++; $display("FAIL en_hold2 d=%0d got=%b exp=0", d, bit_out); end
                    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL en_fs_gap d=%0d got=%b exp=0", d, frame_start); end
                end
            end
        end
        checks++; if (ones != 257) begin failures++; $display("FAIL en_ones got=%0d exp=257", ones); end
    endtask

    initial begin
        test_reset();
        test_midscale();
        test_density();
        test_code_change();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
